// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

    localparam int unsigned ADDR_W_DEF  = 7;
    localparam logic [3:0]  HALT_OPCODE = 4'h5;

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StHi,
        StLo,
        StWrite,
        StCheck,
        StRun,
        StErr
    } state_t;

    // Word count must be 1..2**addr_w so every word lands at a distinct address.
    function automatic logic count_legal(input logic [7:0] n, input int unsigned addr_w);
        return (n != 8'd0) && (32'(n) <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/loader_checksum.sv
// 8-bit XOR accumulator over the loader byte stream.
module loader_checksum (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic [7:0] i_byte,
    output logic [7:0] o_sum
);

    logic [7:0] r_sum;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_sum <= 8'd0;
        end else if (i_en) begin
            r_sum <= r_sum ^ i_byte;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/program_loader.sv
// Streams a counted, checksummed program into instruction memory and releases
// the processor from reset only after a good load.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [7:0]        i_data_in,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    output logic [ADDR_W-1:0] o_im_addr,
    output logic [DATA_W-1:0] o_im_data,
    output logic              o_im_wr,
    output logic              o_proc_reset,
    output logic              o_done,
    output logic              o_error,
    output logic              o_halt_seen
);

    localparam int unsigned CW = (ADDR_W + 1 > 8) ? ADDR_W + 1 : 8;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [7:0]          r_count;
    logic                r_wr;
    logic                r_done;
    logic                r_error;
    logic                r_halt;

    logic                w_ready;
    logic                w_accept;
    logic                w_idle_like;
    logic                w_ck_clear;
    logic                w_ck_en;
    logic [7:0]          w_sum;
    logic [CW-1:0]       w_words;
    logic                w_last;

    assign w_ready     = (r_state == StCount) || (r_state == StHi) ||
                         (r_state == StLo)    || (r_state == StCheck);
    assign w_accept    = w_ready && i_data_valid;
    assign w_idle_like = (r_state == StIdle) || (r_state == StRun) || (r_state == StErr);
    assign w_ck_clear  = w_idle_like && i_start;
    assign w_ck_en     = w_accept && (r_state != StCheck);

    // Words written so far, counting the one being written this cycle.
    assign w_words = CW'(r_addr) + CW'(1);
    assign w_last  = (w_words == CW'(r_count));

    loader_checksum u_checksum (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_ck_clear),
        .i_en    (w_ck_en),
        .i_byte  (i_data_in),
        .o_sum   (w_sum)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_data  <= '0;
            r_count <= 8'd0;
            r_wr    <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_halt  <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                StIdle, StRun, StErr: begin
                    if (i_start) begin
                        r_state <= StCount;
                        r_addr  <= '0;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                        r_halt  <= 1'b0;
                    end
                end
                StCount: begin
                    if (w_accept) begin
                        r_count <= i_data_in;
                        if (count_legal(i_data_in, ADDR_W)) begin
                            r_state <= StHi;
                        end else begin
                            r_state <= StErr;
                            r_error <= 1'b1;
                        end
                    end
                end
                StHi: begin
                    if (w_accept) begin
                        r_data[15:8] <= i_data_in;
                        r_state      <= StLo;
                    end
                end
                StLo: begin
                    if (w_accept) begin
                        r_data[7:0] <= i_data_in;
                        r_wr        <= 1'b1;
                        r_state     <= StWrite;
                    end
                end
                StWrite: begin
                    if (r_data[15:12] == HALT_OPCODE) begin
                        r_halt <= 1'b1;
                    end
                    if (w_last) begin
                        r_state <= StCheck;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= StHi;
                    end
                end
                StCheck: begin
                    if (w_accept) begin
                        if (i_data_in == w_sum) begin
                            r_state <= StRun;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StErr;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_data_ready = w_ready;
    assign o_proc_reset = (r_state != StRun);
    assign o_im_addr    = r_addr;
    assign o_im_data    = r_data;
    assign o_im_wr      = r_wr;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_halt_seen  = r_halt;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/bad loads, illegal counts, stalls, reset, full depth.
module tb_program_loader;

    localparam int LIMIT = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic [6:0]  im_addr;
    logic [15:0] im_data;
    logic        im_wr;
    logic        proc_reset;
    logic        done;
    logic        error;
    logic        halt_seen;

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          fall_cyc = 0;
    int          n_fall   = 0;
    logic        prev_pr  = 1'b1;
    logic        bp       = 1'b0;
    logic [6:0]  wa_q[$];
    logic [15:0] wd_q[$];

    program_loader dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_data_in    (data_in),
        .i_data_valid (data_valid),
        .o_data_ready (data_ready),
        .o_im_addr    (im_addr),
        .o_im_data    (im_data),
        .o_im_wr      (im_wr),
        .o_proc_reset (proc_reset),
        .o_done       (done),
        .o_error      (error),
        .o_halt_seen  (halt_seen)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log and Proc_Reset edge monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (im_wr === 1'b1) begin
            wa_q.push_back(im_addr);
            wd_q.push_back(im_data);
        end
        if (prev_pr === 1'b1 && proc_reset === 1'b0) begin
            fall_cyc = cyc;
            n_fall++;
        end
        prev_pr = proc_reset;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(output int t0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        if (bp) begin
            data_valid = 1'b0;
            @(negedge clk);
        end
        data_in    = b;
        data_valid = 1'b1;
        guard      = 0;
        while (data_ready !== 1'b1 && guard < LIMIT) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= LIMIT) begin
            n_checks++;
            n_err++;
            $error("FAIL ready_timeout: observed=stalled expected=ready within %0d cycles", LIMIT);
        end
        @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] last);
        logic [7:0] s [6];
        s = '{8'h02, 8'h20, 8'h01, 8'h50, 8'h00, 8'h00};
        s[5] = last;
        for (int i = 0; i < 6; i++) send_byte(s[i]);
        data_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        n_fall = 0;
    endtask

    task automatic chk_two_writes(input string tag);
        chk({tag, "_nwr"}, wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            chk({tag, "_a0"}, wa_q[0], 0);
            chk({tag, "_d0"}, wd_q[0], 16'h2001);
            chk({tag, "_a1"}, wa_q[1], 1);
            chk({tag, "_d1"}, wd_q[1], 16'h5000);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, data_ready, 0);
        chk({tag, "_addr"}, im_addr, 0);
        chk({tag, "_data"}, im_data, 0);
        chk({tag, "_wr"}, im_wr, 0);
        chk({tag, "_preset"}, proc_reset, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_halt"}, halt_seen, 0);
    endtask

    initial begin
        int         t0;
        logic [7:0] cs;
        logic [15:0] w;

        reset      = 1'b1;
        start      = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        // Good load, valid held high: count + 3N + check cycles until RUN.
        clear_log();
        do_start(t0);
        send_good(8'h73);
        chk_two_writes("good");
        chk("good_done", done, 1);
        chk("good_error", error, 0);
        chk("good_halt", halt_seen, 1);
        chk("good_preset", proc_reset, 0);
        chk("good_nfall", n_fall, 1);
        chk("good_latency", fall_cyc - t0, 1 + 3 * 2 + 1);

        // Bad checksum, restarted from RUN.
        clear_log();
        do_start(t0);
        chk("restart_preset", proc_reset, 1);
        chk("restart_done_clr", done, 0);
        send_good(8'h72);
        chk_two_writes("bad");
        chk("bad_error", error, 1);
        chk("bad_done", done, 0);
        chk("bad_preset", proc_reset, 1);
        chk("bad_nfall", n_fall, 0);

        // Illegal counts.
        clear_log();
        do_start(t0);
        chk("zero_err_clr", error, 0);
        send_byte(8'h00);
        data_valid = 1'b0;
        @(negedge clk);
        chk("zero_error", error, 1);
        chk("zero_ready", data_ready, 0);
        chk("zero_nwr", wa_q.size(), 0);
        do_start(t0);
        send_byte(8'h81);
        data_valid = 1'b0;
        @(negedge clk);
        chk("big_error", error, 1);
        chk("big_preset", proc_reset, 1);
        chk("big_nwr", wa_q.size(), 0);

        // Backpressure: valid drops between every byte.
        clear_log();
        bp = 1'b1;
        do_start(t0);
        send_good(8'h73);
        bp = 1'b0;
        chk_two_writes("bp");
        chk("bp_done", done, 1);
        chk("bp_error", error, 0);
        chk("bp_halt", halt_seen, 1);

        // Reset one cycle after the first HI accept, then a clean reload.
        clear_log();
        do_start(t0);
        send_byte(8'h02);
        send_byte(8'h20);
        reset      = 1'b1;
        data_valid = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_nwr", wa_q.size(), 0);
        do_start(t0);
        send_good(8'h73);
        chk_two_writes("reload");
        chk("reload_done", done, 1);

        // Full depth: 128 words, data = address, last word is a halt.
        clear_log();
        do_start(t0);
        cs = 8'h80;
        send_byte(8'h80);
        for (int i = 0; i < 128; i++) begin
            w  = (i == 127) ? 16'h5000 : 16'(i);
            cs = cs ^ w[15:8] ^ w[7:0];
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        send_byte(cs);
        data_valid = 1'b0;
        @(negedge clk);
        chk("full_cs", cs, 8'hAF);
        chk("full_nwr", wa_q.size(), 128);
        if (wa_q.size() == 128) begin
            chk("full_a5", wa_q[5], 5);
            chk("full_d5", wd_q[5], 5);
            chk("full_alast", wa_q[127], 7'h7F);
            chk("full_dlast", wd_q[127], 16'h5000);
        end
        chk("full_addr_hold", im_addr, 7'h7F);
        chk("full_done", done, 1);
        chk("full_preset", proc_reset, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
